// File: rtl/issue_decode_pkg.sv
// Shared definitions for the issue/decode slice: opcodes, ALUop encodings,
// instruction field positions, func codes, decoded-instruction and
// scoreboard-entry structs, and the head-of-buffer decode helpers.
package issue_decode_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'b000000;
    localparam logic [5:0] OP_BEQ      = 6'b000100;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_RTYPE = 2'b10;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RS_HI  = 25;
    localparam int RS_LO  = 21;
    localparam int RT_HI  = 20;
    localparam int RT_LO  = 16;
    localparam int RD_HI  = 15;
    localparam int RD_LO  = 11;
    localparam int FN_HI  = 5;
    localparam int FN_LO  = 0;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    typedef struct packed {
        logic [1:0] aluop;
        logic [5:0] func;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic       we;
    } dec_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       we;
    } sb_ent_t;

    typedef enum logic [1:0] {
        ACT_IDLE    = 2'd0,
        ACT_ISSUE   = 2'd1,
        ACT_STALL   = 2'd2,
        ACT_ILLEGAL = 2'd3
    } act_e;

    function automatic logic is_legal(input logic [31:0] w);
        return (w[OPC_HI:OPC_LO] == OP_RTYPE) || (w[OPC_HI:OPC_LO] == OP_BEQ);
    endfunction

    // Source fields are always extracted; only R-type carries rd/func/we.
    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        d       = '0;
        d.rs1   = w[RS_HI:RS_LO];
        d.rs2   = w[RT_HI:RT_LO];
        case (w[OPC_HI:OPC_LO])
            OP_RTYPE: begin
                d.aluop = ALUOP_RTYPE;
                d.func  = w[FN_HI:FN_LO];
                d.rd    = w[RD_HI:RD_LO];
                d.we    = 1'b1;
            end
            OP_BEQ: begin
                d.aluop = ALUOP_SUB;
            end
            default: begin
                d.aluop = ALUOP_ADD;
            end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/issue_decode_instr_fifo.sv
// instr_fifo: generic synchronous FIFO holding raw instruction words.
// Latency: a pushed word is visible on o_head one edge later; pop is same-edge.
// Backpressure: pushes while full are ignored, pops while empty are ignored.
// Ports: clk/rst (async, active-high), i_push/i_dat write side,
//        i_pop read side, o_head current oldest word, o_full/o_empty status.
module instr_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rptr];

    // Storage needs no reset: occupancy alone defines what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= i_dat;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/issue_decode.sv
// issue_decode: instruction buffer + decode/issue stage with RAW bubble insertion.
// Latency: word pushed into an empty buffer appears decoded after the next edge.
// Backpressure: in_ready = !full; head is held (stalled) while a RAW hazard exists.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_instr input port;
//        ALUop/func/rs1/rs2/rd/we decoded fields; issue_valid, hazard_stall,
//        illegal status pulses. All decode outputs are registered.
module issue_decode
    import issue_decode_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int HAZ_WIN    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    output logic [1:0]  ALUop,
    output logic [5:0]  func,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        we,
    output logic        issue_valid,
    output logic        hazard_stall,
    output logic        illegal
);

    logic        w_full;
    logic        w_empty;
    logic [31:0] w_head;
    logic        w_pop;
    logic        w_hazard;
    dec_t        w_dec;
    act_e        w_act;

    // Writers issued in the last HAZ_WIN cycles; index 0 is the most recent.
    sb_ent_t     r_sb [HAZ_WIN];

    assign in_ready = !w_full;

    instr_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (32)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (in_valid && in_ready),
        .i_dat   (in_instr),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign w_dec = decode(w_head);

    // No forwarding: any in-flight writer of either source blocks issue.
    // $0 is compared like any other register since the RF really writes it.
    always_comb begin
        w_hazard = 1'b0;
        for (int i = 0; i < HAZ_WIN; i++) begin
            if (r_sb[i].we && ((r_sb[i].rd == w_dec.rs1) || (r_sb[i].rd == w_dec.rs2))) begin
                w_hazard = 1'b1;
            end
        end
    end

    always_comb begin
        w_act = ACT_IDLE;
        if (!w_empty) begin
            if (!is_legal(w_head)) begin
                w_act = ACT_ILLEGAL;
            end else if (w_hazard) begin
                w_act = ACT_STALL;
            end else begin
                w_act = ACT_ISSUE;
            end
        end
    end

    assign w_pop = (w_act == ACT_ISSUE) || (w_act == ACT_ILLEGAL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ALUop        <= ALUOP_ADD;
            func         <= '0;
            rs1          <= '0;
            rs2          <= '0;
            rd           <= '0;
            we           <= 1'b0;
            issue_valid  <= 1'b0;
            hazard_stall <= 1'b0;
            illegal      <= 1'b0;
            for (int i = 0; i < HAZ_WIN; i++) begin
                r_sb[i] <= '0;
            end
        end else begin
            // Bubble by default; only an issue drives real fields.
            ALUop        <= ALUOP_ADD;
            func         <= '0;
            rs1          <= '0;
            rs2          <= '0;
            rd           <= '0;
            we           <= 1'b0;
            issue_valid  <= 1'b0;
            hazard_stall <= (w_act == ACT_STALL);
            illegal      <= (w_act == ACT_ILLEGAL);
            if (w_act == ACT_ISSUE) begin
                ALUop       <= w_dec.aluop;
                func        <= w_dec.func;
                rs1         <= w_dec.rs1;
                rs2         <= w_dec.rs2;
                rd          <= w_dec.rd;
                we          <= w_dec.we;
                issue_valid <= 1'b1;
            end

            // Scoreboard shifts every cycle; bubbles age out older writers.
            r_sb[0].rd <= (w_act == ACT_ISSUE) ? w_dec.rd : 5'd0;
            r_sb[0].we <= (w_act == ACT_ISSUE) && w_dec.we;
            for (int i = 1; i < HAZ_WIN; i++) begin
                r_sb[i] <= r_sb[i-1];
            end
        end
    end

endmodule
